// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions for the modulo counter and its digit cells.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  // Per-digit step request; ld takes priority over up/dn inside the digit.
  typedef struct packed {
    logic up;
    logic dn;
    logic ld;
    bcd_t ld_val;
  } dig_ctrl_t;

  function automatic logic bcd_ok(input bcd_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit: load, increment with 9->0 wrap, decrement with 0->9 wrap.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  dig_ctrl_t ctrl_i,
  output bcd_t      digit_o,
  output logic      at_max_o,
  output logic      at_zero_o
);
  bcd_t digit_q, digit_d;

  assign digit_o   = digit_q;
  assign at_max_o  = (digit_q == BCD_MAX);
  assign at_zero_o = (digit_q == '0);

  always_comb begin
    digit_d = digit_q;
    if (ctrl_i.ld)
      digit_d = ctrl_i.ld_val;
    else if (ctrl_i.up)
      digit_d = at_max_o ? '0 : digit_q + 4'd1;
    else if (ctrl_i.dn)
      digit_d = at_zero_o ? BCD_MAX : digit_q - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) digit_q <= '0;
    else     digit_q <= digit_d;
  end
endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter modulo MOD with load, carry and borrow for chaining.
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int MOD       = 60,
  parameter bit CA_ON_INC = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       INC,
  input  logic       DEC,
  input  logic       LD,
  input  logic [3:0] DH,
  input  logic [3:0] DL,
  output logic [3:0] QH,
  output logic [3:0] QL,
  output logic       CA,
  output logic       BO,
  output logic       ERR
);
  localparam int   NUM_DIG = 2;
  localparam int   TOP     = MOD - 1;
  localparam bcd_t TOP_H   = bcd_t'(TOP / 10);
  localparam bcd_t TOP_L   = bcd_t'(TOP % 10);

  generate
    if (MOD < 2 || MOD > 100) begin : g_bad_mod
      $error("bcd_mod_counter: MOD must be in 2..100");
    end
  endgenerate

  dig_ctrl_t [NUM_DIG-1:0] ctrl;
  bcd_t      [NUM_DIG-1:0] dig;
  logic      [NUM_DIG-1:0] at_max, at_zero;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    bcd_digit u_dig (
      .CLK      (CLK),
      .RST      (RST),
      .ctrl_i   (ctrl[i]),
      .digit_o  (dig[i]),
      .at_max_o (at_max[i]),
      .at_zero_o(at_zero[i])
    );
  end

  logic up, dn, at_top, at_bot, ld_ok;
  logic err_q, err_d;

  assign up     = EN | INC;
  assign dn     = DEC & ~up;
  assign at_top = (dig[1] == TOP_H) && (dig[0] == TOP_L);
  assign at_bot = at_zero[1] & at_zero[0];

  // Digit-wise range check keeps every compare at 4 bits.
  assign ld_ok = bcd_ok(DH) && bcd_ok(DL) &&
                 ((DH < TOP_H) || ((DH == TOP_H) && (DL <= TOP_L)));

  // Modulus wraps are done as loads so the digits themselves stay mod-10.
  always_comb begin
    ctrl = '0;
    if (LD) begin
      ctrl[1].ld     = 1'b1;
      ctrl[0].ld     = 1'b1;
      ctrl[1].ld_val = ld_ok ? bcd_t'(DH) : '0;
      ctrl[0].ld_val = ld_ok ? bcd_t'(DL) : '0;
    end else if (up && at_top) begin
      ctrl[1].ld = 1'b1;
      ctrl[0].ld = 1'b1;
    end else if (up) begin
      ctrl[0].up = 1'b1;
      ctrl[1].up = at_max[0] & ~at_max[1];
    end else if (dn && at_bot) begin
      ctrl[1].ld     = 1'b1;
      ctrl[0].ld     = 1'b1;
      ctrl[1].ld_val = TOP_H;
      ctrl[0].ld_val = TOP_L;
    end else if (dn) begin
      ctrl[0].dn = 1'b1;
      ctrl[1].dn = at_zero[0];
    end
  end

  assign err_d = LD & ~ld_ok;

  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign QH  = dig[1];
  assign QL  = dig[0];
  assign ERR = err_q;
  assign CA  = at_top & (EN | (CA_ON_INC & INC));
  assign BO  = at_bot & DEC & ~up;
endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 The block SHALL have parameter MOD, default 60: the count modulus, legal range 2..100, so the count runs 0..MOD-1.
REQ-002 The block SHALL have parameter CA_ON_INC, default 0: when 1, INC also qualifies CA; when 0, only EN qualifies CA.
REQ-003 The block SHALL have port CLK, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port EN, input, 1 bit: count-up tick from the lower-order stage's carry.
REQ-006 The block SHALL have port INC, input, 1 bit: manual up-step (time-set button).
REQ-007 The block SHALL have port DEC, input, 1 bit: manual down-step.
REQ-008 The block SHALL have port LD, input, 1 bit: load strobe for DH/DL.
REQ-009 The block SHALL have port DH, input, 4 bits: BCD tens digit to load.
REQ-010 The block SHALL have port DL, input, 4 bits: BCD ones digit to load.
REQ-011 The block SHALL have port QH, output, 4 bits: registered BCD tens digit.
REQ-012 The block SHALL have port QL, output, 4 bits: registered BCD ones digit.
REQ-013 The block SHALL have port CA, output, 1 bit: combinational carry to the next stage.
REQ-014 The block SHALL have port BO, output, 1 bit: combinational borrow to the next stage.
REQ-015 The block SHALL have port ERR, output, 1 bit: registered one-cycle flag for a rejected load.

Function
REQ-016 The block SHALL treat the count value as V = 10*QH + QL, with QL always in 0..9 and V always in 0..MOD-1.
REQ-017 The block SHALL apply per-cycle priority: RST, then LD, then up (up = EN or INC), then down (DEC and not up).
REQ-018 On up, the block SHALL step V to V+1, with V = MOD-1 wrapping to 0 (QL 9 -> 0 increments QH).
REQ-019 On down, the block SHALL step V to V-1, with V = 0 wrapping to MOD-1 (QL 0 -> 9 decrements QH).
REQ-020 With EN, INC and DEC all 0 and LD low, the block SHALL hold the count.
REQ-021 On a valid LD (DL <= 9, DH <= 9 and 10*DH+DL < MOD), the block SHALL set QH=DH and QL=DL on the next edge.
REQ-022 LD SHALL override EN/INC/DEC in the same cycle.
REQ-023 On an invalid LD, the block SHALL set QH=0 and QL=0, and ERR SHALL be 1 for exactly the following cycle.
REQ-024 ERR SHALL be 0 in every other cycle, including consecutive valid loads.
REQ-025 CA SHALL equal (V == MOD-1) AND (EN, or INC when CA_ON_INC=1), independent of LD and DEC.
REQ-026 BO SHALL equal (V == 0) AND DEC AND NOT (EN or INC).
REQ-027 CA and BO SHALL be driven by current register state and inputs only, giving zero-cycle latency, and SHALL never both be 1.
REQ-028 For MOD <= 10, QH SHALL stay 0 permanently.
REQ-029 The block SHALL use no arithmetic wider than 4 bits per digit.

Reset
REQ-030 When RST=1 at a clock edge, the block SHALL set QH=0, QL=0 and ERR=0, regardless of LD/EN/INC/DEC.
REQ-031 During RST, CA SHALL follow its equation on the current state, so CA=0 after the first reset edge.
REQ-032 Deasserting RST mid-sequence SHALL resume counting from 00 on the first edge with RST=0.

Structure
REQ-033 The shared package bcd_pkg SHALL hold BCD_W=4, BCD_MAX=4'd9 and a BCD digit typedef.
REQ-034 Each digit SHALL be an instance of sub-module bcd_digit (inputs up/down/load/wrap value; outputs digit, at_max, at_zero).
REQ-035 The top level SHALL chain the digit instances and derive the MOD-specific wrap decode.
REQ-036 The top level SHALL reject illegal MOD at elaboration.

Verification
REQ-037 Reset: RST=1 for 2 cycles with EN=1 and the count at 37 -> QH/QL=0/0, ERR=0.
REQ-038 Up-wrap, MOD=60: load 58, EN=1 for 2 cycles -> 59 then 00; CA=1 only in the cycle V=59.
REQ-039 INC vs CA, CA_ON_INC=0: at 59 with INC=1 -> next count 00 and CA=0 throughout.
REQ-040 Down-wrap: at 00 with DEC=1 -> BO=1 and next count 59; at 00 with EN=1 and DEC=1 -> BO=0 and next count 01.
REQ-041 Load check: DH/DL=4/2 -> 42 and ERR=0; then DH/DL=7/10 -> 00 and ERR=1 for one cycle; then LD with EN=1 at V=59 -> load wins and CA=1.
REQ-042 MOD=24: EN from 22 -> 23, 00; DEC from 00 -> 23; LD of 2/4 -> 00 and ERR=1.
